// File: rtl/approx_add_pkg.sv
// Shared constants, result record and saturating helper for the approximate-adder arbiter.
package approx_add_pkg;

    localparam int DEFAULT_NREQ        = 4;
    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_APPROX_BITS = 5;
    localparam int DEFAULT_IDW         = $clog2(DEFAULT_NREQ);

    typedef struct packed {
        logic [DEFAULT_WIDTH:0]   sum;
        logic [DEFAULT_IDW-1:0]   id;
    } rsp_rec_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [31:0] inc);
        logic [32:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/approx_add_arbiter_adder.sv
// Combinational ripple-carry adder whose low APPROX_BITS positions pass a[k] through
// and forward b[k] as carry; upper positions are exact full adders.
module approx_rc_adder #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] c;

    always_comb begin
        c   = '0;
        sum = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (k < APPROX_BITS) begin
                sum[k]   = a[k];
                c[k+1]   = b[k];
            end else begin
                sum[k]   = a[k] ^ b[k] ^ c[k];
                c[k+1]   = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
            end
        end
        sum[WIDTH] = c[WIDTH];
    end

endmodule

// File: rtl/approx_add_arbiter.sv
// Round-robin shared approximate adder with a one-entry registered result stage.
// Define APPROX_ADD_ERRMON_EN to add the exact-sum error monitor (err_* ports).
module approx_add_arbiter
    import approx_add_pkg::*;
#(
    parameter int  NREQ        = DEFAULT_NREQ,
    parameter int  WIDTH       = DEFAULT_WIDTH,
    parameter int  APPROX_BITS = DEFAULT_APPROX_BITS,
    localparam int IDW         = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH:0]        rsp_sum,
    output logic [IDW-1:0]        rsp_id
`ifdef APPROX_ADD_ERRMON_EN
    ,
    input  logic                  err_clr,
    output logic [31:0]           err_cnt,
    output logic [31:0]           err_abs
`endif
);

    typedef struct packed {
        logic [WIDTH:0] sum;
        logic [IDW-1:0] id;
    } rec_t;

    logic [IDW-1:0]   last_q, last_d;
    rec_t             rsp_q, rsp_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             ld, found, grant;
    logic [IDW-1:0]   gnt_idx, cand;
    logic [WIDTH-1:0] a_mux, b_mux;
    logic [WIDTH:0]   approx_sum;

    assign ld = !rsp_valid_q || rsp_ready;

    // Search begins just after the last winner so every requester is reached within NREQ-1 grants.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDW'((int'(last_q) + off) % NREQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant = rst_n && ld && found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        a_mux = '0;
        b_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_mux = req_a[i*WIDTH +: WIDTH];
                b_mux = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    approx_rc_adder #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_approx (
        .a   (a_mux),
        .b   (b_mux),
        .sum (approx_sum)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        last_d      = last_q;
        if (grant) begin
            rsp_valid_d = 1'b1;
            rsp_d.sum   = approx_sum;
            rsp_d.id    = gnt_idx;
            last_d      = gnt_idx;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            last_q      <= IDW'(NREQ - 1);
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            last_q      <= last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_q.sum;
    assign rsp_id    = rsp_q.id;

`ifdef APPROX_ADD_ERRMON_EN
    logic [WIDTH:0] exact_sum, abs_diff;
    logic [31:0]    err_cnt_q, err_cnt_d, err_abs_q, err_abs_d;

    approx_rc_adder #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (0)
    ) u_exact (
        .a   (a_mux),
        .b   (b_mux),
        .sum (exact_sum)
    );

    assign abs_diff = (approx_sum >= exact_sum) ? (approx_sum - exact_sum) : (exact_sum - approx_sum);

    // Clear wins over an update landing in the same cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        err_abs_d = err_abs_q;
        if (err_clr) begin
            err_cnt_d = '0;
            err_abs_d = '0;
        end else if (grant) begin
            err_cnt_d = sat_add32(err_cnt_q, 32'(approx_sum != exact_sum));
            err_abs_d = sat_add32(err_abs_q, 32'(abs_diff));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            err_abs_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_abs_q <= err_abs_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_abs = err_abs_q;
`else
    // Monitor absent in this build.
`endif

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Randomized bench for approx_add_arbiter against an arithmetic reference model.
module tb_approx_add_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int AB    = 5;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic                  rsp_valid, rsp_ready;
    logic [WIDTH:0]        rsp_sum;
    logic [IDW-1:0]        rsp_id;
`ifdef APPROX_ADD_ERRMON_EN
    logic                  err_clr;
    logic [31:0]           err_cnt, err_abs;
`endif

    approx_add_arbiter #(
        .NREQ        (NREQ),
        .WIDTH       (WIDTH),
        .APPROX_BITS (AB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef APPROX_ADD_ERRMON_EN
        ,
        .err_clr   (err_clr),
        .err_cnt   (err_cnt),
        .err_abs   (err_abs)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference state
    bit          m_valid;
    int unsigned m_sum, m_id;
    int          m_last;
    int unsigned m_ecnt, m_eabs;
    int          last_gnt;

    logic [WIDTH-1:0] a_v [NREQ];
    logic [WIDTH-1:0] b_v [NREQ];
    bit   [NREQ-1:0]  pend;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Low AB bits copy a; the carry into the exact part is b[AB-1].
    function automatic int unsigned ref_approx(input int unsigned a, input int unsigned b);
        int unsigned cin, lo;
        if (AB == 0) return a + b;
        cin = (b >> (AB - 1)) & 1;
        lo  = a & ((1 << AB) - 1);
        return (((a >> AB) + (b >> AB) + cin) << AB) | lo;
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_sum = 0; m_id = 0; m_last = NREQ - 1;
        m_ecnt = 0; m_eabs = 0; last_gnt = -1;
    endtask

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_v[i];
            req_b[i*WIDTH +: WIDTH] = b_v[i];
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        bit              ld;
        int              g;
        int unsigned     a, b, ap, ex;
        bit              clr;
        #1;
        ld = !m_valid || rsp_ready;
        g  = -1;
        if (ld) begin
            for (int off = 1; off <= NREQ; off++) begin
                int c;
                c = (m_last + off) % NREQ;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy = NREQ'(1) << g;
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, m_valid);
        if (m_valid) begin
            chk("rsp_sum", rsp_sum, m_sum);
            chk("rsp_id", rsp_id, m_id);
        end
        clr = 0;
`ifdef APPROX_ADD_ERRMON_EN
        chk("err_cnt", err_cnt, m_ecnt);
        chk("err_abs", err_abs, m_eabs);
        clr = err_clr;
`endif
        a = 0; b = 0;
        if (g >= 0) begin
            a = a_v[g];
            b = b_v[g];
        end
        @(posedge clk);
        if (g >= 0) begin
            ap = ref_approx(a, b);
            ex = a + b;
            m_valid = 1; m_sum = ap; m_id = g; m_last = g;
            if (!clr) begin
                m_ecnt += (ap != ex) ? 1 : 0;
                m_eabs += (ap > ex) ? ap - ex : ex - ap;
            end
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        if (clr) begin
            m_ecnt = 0; m_eabs = 0;
        end
        last_gnt = g;
        @(negedge clk);
    endtask

    task automatic directed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH:0] exp_sum, input string tag);
        a_v[0] = a; b_v[0] = b; pack();
        req_valid = 4'b0001;
        step();
        chk({tag, "_sum"}, rsp_sum, exp_sum);
        chk({tag, "_id"}, rsp_id, 0);
        req_valid = '0;
        step();
    endtask

    initial begin
        logic [WIDTH:0] held_sum;
        logic [IDW-1:0] held_id;
        int             exp_g;

        rst_n = 0; rsp_ready = 1; req_valid = '0; req_a = '0; req_b = '0;
`ifdef APPROX_ADD_ERRMON_EN
        err_clr = 0;
`endif
        for (int i = 0; i < NREQ; i++) begin a_v[i] = '0; b_v[i] = '0; end
        model_reset();
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst_ready", req_ready, '0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_id", rsp_id, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1;

        directed(16'h0003, 16'h0001, 17'h00003, "tp1");
`ifdef APPROX_ADD_ERRMON_EN
        chk("tp1_ecnt", err_cnt, 1);
        chk("tp1_eabs", err_abs, 1);
`endif
        directed(16'h1234, 16'h0010, 17'h01254, "tp2");
        directed(16'hFFFF, 16'hFFFF, 17'h1FFFF, "tp3");

        // all requesters busy: strict rotation starting after requester 0
        for (int i = 0; i < NREQ; i++) begin a_v[i] = rand_op(); b_v[i] = rand_op(); end
        pack();
        req_valid = '1; rsp_ready = 1;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_g = (1 + k) % NREQ;
            chk("rr_order", last_gnt, exp_g);
            if (last_gnt >= 0) begin a_v[last_gnt] = rand_op(); b_v[last_gnt] = rand_op(); pack(); end
        end

        // backpressure: result held, no grants
        rsp_ready = 0;
        held_sum = rsp_sum;
        held_id  = rsp_id;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_sum", rsp_sum, held_sum);
            chk("hold_id", rsp_id, held_id);
        end
        rsp_ready = 1;
        step();
        chk("release_gnt", last_gnt >= 0, 1);

        // randomized traffic with requesters holding until accepted
        pend = '0;
        req_valid = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1; a_v[i] = rand_op(); b_v[i] = rand_op();
                end
            end
            pack();
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef APPROX_ADD_ERRMON_EN
            err_clr = ($urandom_range(0, 19) == 0);
`endif
            step();
            if (last_gnt >= 0) pend[last_gnt] = 0;
        end
`ifdef APPROX_ADD_ERRMON_EN
        err_clr = 0;
`endif

        // asynchronous reset while FULL
        req_valid = '1; rsp_ready = 0; pack();
        step();
        chk("full_before_rst", rsp_valid, 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_valid", rsp_valid, 0);
        chk("async_rst_ready", req_ready, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        rsp_ready = 1;
        step();
        chk("post_rst_gnt", last_gnt, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
